// File: rtl/seg7_scan_ctrl_if.sv
// Bus bundle between the counter datapath and the 7-segment scan controller.
// The master drives frame data and display controls; the slave returns the scan outputs.
interface seg7_scan_ctrl_if #(
  parameter int N_DIGITS = 2
);
  logic [4*N_DIGITS-1:0] digits_in;
  logic [N_DIGITS-1:0]   dp_in;
  logic                  load;
  logic [N_DIGITS-1:0]   digit_en;
  logic                  lz_blank;
  logic [3:0]            bin_out;
  logic [N_DIGITS-1:0]   an_out;
  logic                  dp_out;
  logic                  frame_done;

  modport master (
    output digits_in, dp_in, load, digit_en, lz_blank,
    input  bin_out, an_out, dp_out, frame_done
  );

  modport slave (
    input  digits_in, dp_in, load, digit_en, lz_blank,
    output bin_out, an_out, dp_out, frame_done
  );
endinterface

// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed 7-segment scan controller. It double-buffers the frame, adds a dark
// guard at the start of each digit slot and blanks leading zeros.
module seg7_scan_ctrl #(
  parameter int N_DIGITS     = 2,
  parameter int REFRESH_DIV  = 50000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  seg7_scan_ctrl_if.slave bus
);
  localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam logic [CNT_W-1:0]    CNT_LAST  = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0]    GUARD_END = CNT_W'(BLANK_CYCLES);
  localparam logic [IDX_W-1:0]    IDX_LAST  = IDX_W'(N_DIGITS - 1);
  localparam logic [N_DIGITS-1:0] AN_ONE    = N_DIGITS'(1);

  typedef enum logic {PH_GUARD = 1'b0, PH_ON = 1'b1} phase_t;

  logic [CNT_W-1:0]              r_cnt;
  logic [IDX_W-1:0]              r_idx;
  phase_t                        r_phase;
  logic                          r_frame_done;
  logic [N_DIGITS-1:0][3:0]      r_sh_dig;
  logic [N_DIGITS-1:0]           r_sh_dp;
  logic [N_DIGITS-1:0][3:0]      r_dsp_dig;
  logic [N_DIGITS-1:0]           r_dsp_dp;

  logic                          w_cnt_wrap;
  logic                          w_frame_end;
  logic [CNT_W-1:0]              w_cnt_nxt;
  logic [IDX_W-1:0]              w_idx_nxt;
  logic                          w_upper_zero;
  logic                          w_lead_zero;
  logic                          w_lit;

  // Next-state arithmetic for the slot counter and digit index.
  always_comb begin
    w_cnt_wrap  = (r_cnt == CNT_LAST);
    w_frame_end = w_cnt_wrap && (r_idx == IDX_LAST);
    if (w_cnt_wrap) begin
      w_cnt_nxt = {CNT_W{1'b0}};
    end else begin
      w_cnt_nxt = r_cnt + CNT_W'(1);
    end
    if (!w_cnt_wrap) begin
      w_idx_nxt = r_idx;
    end else if (r_idx == IDX_LAST) begin
      w_idx_nxt = {IDX_W{1'b0}};
    end else begin
      w_idx_nxt = r_idx + IDX_W'(1);
    end
  end

  // Scan state, shadow/display buffers and the lookahead-registered phase and frame pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt        <= {CNT_W{1'b0}};
      r_idx        <= {IDX_W{1'b0}};
      r_phase      <= PH_GUARD;
      r_frame_done <= 1'b0;
      r_sh_dig     <= '0;
      r_sh_dp      <= {N_DIGITS{1'b0}};
      r_dsp_dig    <= '0;
      r_dsp_dp     <= {N_DIGITS{1'b0}};
    end else begin
      r_cnt        <= w_cnt_nxt;
      r_idx        <= w_idx_nxt;
      r_phase      <= (w_cnt_nxt < GUARD_END) ? PH_GUARD : PH_ON;
      r_frame_done <= (w_idx_nxt == IDX_LAST) && (w_cnt_nxt == CNT_LAST);
      if (bus.load) begin
        r_sh_dig <= bus.digits_in;
        r_sh_dp  <= bus.dp_in;
      end
      // A load on the commit edge lands in the shadow only; the display takes the old shadow.
      if (w_frame_end) begin
        r_dsp_dig <= r_sh_dig;
        r_dsp_dp  <= r_sh_dp;
      end
    end
  end

  // Output decode: the enable mask and blanking control gate the digit drive live.
  always_comb begin
    w_upper_zero = 1'b1;
    for (int j = 0; j < N_DIGITS; j++) begin
      if ((j >= int'(r_idx)) && (r_dsp_dig[j] != 4'h0)) begin
        w_upper_zero = 1'b0;
      end else begin
        w_upper_zero = w_upper_zero;
      end
    end
    w_lead_zero = bus.lz_blank && (r_idx != {IDX_W{1'b0}}) && w_upper_zero;
    w_lit       = (r_phase == PH_ON) && bus.digit_en[r_idx] && !w_lead_zero;
    if (w_lit) begin
      bus.an_out = AN_ONE << r_idx;
      bus.dp_out = r_dsp_dp[r_idx];
    end else begin
      bus.an_out = {N_DIGITS{1'b0}};
      bus.dp_out = 1'b0;
    end
    bus.bin_out    = r_dsp_dig[r_idx];
    bus.frame_done = r_frame_done;
  end
endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Directed bench for seg7_scan_ctrl with N_DIGITS=2, REFRESH_DIV=10, BLANK_CYCLES=2.
// Cycle 0 is the first cycle after reset release; each scenario restarts from reset.
module tb_seg7_scan_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;

  always #5 clk = ~clk;

  seg7_scan_ctrl_if #(.N_DIGITS(2)) bus ();

  seg7_scan_ctrl #(
    .N_DIGITS(2),
    .REFRESH_DIV(10),
    .BLANK_CYCLES(2)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_an"},  {6'b0, bus.an_out},     8'h00);
    chk({tag, "_bin"}, {4'b0, bus.bin_out},    8'h00);
    chk({tag, "_dp"},  {7'b0, bus.dp_out},     8'h00);
    chk({tag, "_fd"},  {7'b0, bus.frame_done}, 8'h00);
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    bus.load = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("rst");
    rst_n = 1'b1;
    cyc   = 0;
  endtask

  task automatic drive_load(input logic [7:0] d, input logic [1:0] p);
    bus.digits_in = d;
    bus.dp_in     = p;
    bus.load      = 1'b1;
  endtask

  // Compare the current cycle against the hand model for displayed digits dig/dp, then advance.
  task automatic cyc_check(input logic [7:0] dig, input logic [1:0] dp);
    int         cnt;
    int         s;
    logic [3:0] nib;
    logic       lzb;
    logic       on;
    logic [1:0] an;
    logic       dpe;
    logic       fd;
    cnt = cyc % 10;
    s   = (cyc / 10) % 2;
    nib = (s == 1) ? dig[7:4] : dig[3:0];
    lzb = bus.lz_blank && (s == 1) && (dig[7:4] == 4'h0);
    on  = (cnt >= 2) && bus.digit_en[s] && !lzb;
    an  = on ? ((s == 1) ? 2'b10 : 2'b01) : 2'b00;
    dpe = on && dp[s];
    fd  = ((cyc % 20) == 19);
    chk("an_out",     {6'b0, bus.an_out},     {6'b0, an});
    chk("bin_out",    {4'b0, bus.bin_out},    {4'b0, nib});
    chk("dp_out",     {7'b0, bus.dp_out},     {7'b0, dpe});
    chk("frame_done", {7'b0, bus.frame_done}, {7'b0, fd});
    tick();
  endtask

  initial begin
    bus.digits_in = 8'h00;
    bus.dp_in     = 2'b00;
    bus.load      = 1'b0;
    bus.digit_en  = 2'b11;
    bus.lz_blank  = 1'b0;

    // Reset/scan plus load-and-commit: 37 appears only from the second frame.
    do_reset();
    for (int c = 0; c < 40; c++) begin
      if (c == 5) drive_load(8'h37, 2'b01);
      else bus.load = 1'b0;
      cyc_check((c < 20) ? 8'h00 : 8'h37, (c < 20) ? 2'b00 : 2'b01);
    end
    bus.load = 1'b0;

    // Load collides with the commit edge: 11 shows at frame 1, 22 at frame 2.
    do_reset();
    for (int c = 0; c < 60; c++) begin
      if (c == 3) drive_load(8'h11, 2'b00);
      else if (c == 19) drive_load(8'h22, 2'b11);
      else bus.load = 1'b0;
      cyc_check((c < 20) ? 8'h00 : ((c < 40) ? 8'h11 : 8'h22),
                (c < 40) ? 2'b00 : 2'b11);
    end
    bus.load = 1'b0;

    // Leading-zero blanking: digit 1 dark even with its dp set; digit 0 always lit.
    do_reset();
    bus.lz_blank = 1'b1;
    for (int c = 0; c < 60; c++) begin
      if (c == 3) drive_load(8'h05, 2'b10);
      else if (c == 23) drive_load(8'h00, 2'b00);
      else bus.load = 1'b0;
      cyc_check((c >= 20 && c < 40) ? 8'h05 : 8'h00,
                (c >= 20 && c < 40) ? 2'b10 : 2'b00);
    end
    bus.load     = 1'b0;
    bus.lz_blank = 1'b0;

    // Enable mask: slot 0 dark, slot 1 keeps its timing.
    do_reset();
    bus.digit_en = 2'b10;
    for (int c = 0; c < 20; c++) begin
      cyc_check(8'h00, 2'b00);
    end
    bus.digit_en = 2'b11;

    // Mid-frame reset clears outputs at once and discards the pending shadow.
    do_reset();
    for (int c = 0; c < 15; c++) begin
      if (c == 3) drive_load(8'h37, 2'b01);
      else bus.load = 1'b0;
      cyc_check(8'h00, 2'b00);
    end
    chk("pre_rst_an", {6'b0, bus.an_out}, 8'h02);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("async_rst");
    do_reset();
    for (int c = 0; c < 40; c++) begin
      cyc_check(8'h00, 2'b00);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
